// File: rtl/mult_arb_sched.sv
// Round-robin scheduler sharing one pipelined multiplier between two requesters.
// A tag pipeline tracks owner and half-select so each product returns to its requester.
module mult_arb_sched #(
  parameter int unsigned LAT = 4,
  parameter int unsigned W   = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0_valid,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req0_s,
  output logic         req0_ready,
  input  logic         req1_valid,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  input  logic         req1_s,
  output logic         req1_ready,
  output logic [W-1:0] mul_a,
  output logic [W-1:0] mul_b,
  output logic         mul_s,
  input  logic [W-1:0] mul_c,
  output logic         rsp0_valid,
  output logic [W-1:0] rsp0_data,
  output logic         rsp1_valid,
  output logic [W-1:0] rsp1_data,
  output logic [3:0]   inflight
);

  logic           prio_q, prio_d;  // 1: requester 1 wins the next contention
  logic           gnt0, gnt1, xfer;
  logic [W-1:0]   mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  logic [LAT:1]   tag_v_q, tag_v_d;
  logic [LAT:1]   tag_id_q, tag_id_d;
  logic [LAT:1]   tag_s_q, tag_s_d;
  logic           ret_v, ret_id;
  logic           rsp0_valid_q, rsp0_valid_d, rsp1_valid_q, rsp1_valid_d;
  logic [W-1:0]   rsp0_data_q, rsp0_data_d, rsp1_data_q, rsp1_data_d;
  logic [3:0]     inflight_q, inflight_d;

  // NOTE: every signal written here gets a value before any condition, so no latch is inferred.
  always_comb begin
    gnt0   = reset & req0_valid & (~req1_valid | ~prio_q);
    gnt1   = reset & req1_valid & (~req0_valid |  prio_q);
    xfer   = gnt0 | gnt1;

    prio_d  = prio_q;
    mul_a_d = mul_a_q;
    mul_b_d = mul_b_q;
    if (gnt0) begin
      prio_d  = 1'b1;
      mul_a_d = req0_a;
      mul_b_d = req0_b;
    end else if (gnt1) begin
      prio_d  = 1'b0;
      mul_a_d = req1_a;
      mul_b_d = req1_b;
    end

    tag_v_d     = '0;
    tag_id_d    = '0;
    tag_s_d     = '0;
    tag_v_d[1]  = xfer;
    tag_id_d[1] = gnt1;
    tag_s_d[1]  = gnt1 ? req1_s : req0_s;
    for (int i = 2; i <= int'(LAT); i++) begin
      tag_v_d[i]  = tag_v_q[i-1];
      tag_id_d[i] = tag_id_q[i-1];
      tag_s_d[i]  = tag_s_q[i-1];
    end

    ret_v        = tag_v_q[LAT];
    ret_id       = tag_id_q[LAT];
    rsp0_valid_d = ret_v & ~ret_id;
    rsp1_valid_d = ret_v &  ret_id;
    rsp0_data_d  = rsp0_valid_d ? mul_c : rsp0_data_q;
    rsp1_data_d  = rsp1_valid_d ? mul_c : rsp1_data_q;
    inflight_d   = inflight_q + {3'b000, xfer} - {3'b000, ret_v};
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      prio_q       <= 1'b0;
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      tag_v_q      <= '0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_data_q  <= '0;
      rsp1_data_q  <= '0;
      inflight_q   <= '0;
    end else begin
      prio_q       <= prio_d;
      mul_a_q      <= mul_a_d;
      mul_b_q      <= mul_b_d;
      tag_v_q      <= tag_v_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp0_data_q  <= rsp0_data_d;
      rsp1_data_q  <= rsp1_data_d;
      inflight_q   <= inflight_d;
    end
  end

  // NOTE: tag payload needs no reset; it is only observed when its valid bit is set.
  always_ff @(posedge clk) begin
    tag_id_q <= tag_id_d;
    tag_s_q  <= tag_s_d;
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign mul_a      = mul_a_q;
  assign mul_b      = mul_b_q;
  assign mul_s      = tag_v_q[LAT] ? tag_s_q[LAT] : 1'b1;
  assign rsp0_valid = rsp0_valid_q;
  assign rsp0_data  = rsp0_data_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp1_data  = rsp1_data_q;
  assign inflight   = inflight_q;

endmodule

// File: tb/tb_mult_arb_sched.sv
// Bench for mult_arb_sched: a behavioural LAT-cycle multiplier, a table of single
// operations and hand-written sequences for arbitration, ordering and reset.
module tb_mult_arb_sched;
  localparam int LAT = 4;
  localparam int W   = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         req0_valid = 1'b0, req0_s = 1'b0;
  logic [W-1:0] req0_a = '0, req0_b = '0;
  logic         req0_ready;
  logic         req1_valid = 1'b0, req1_s = 1'b0;
  logic [W-1:0] req1_a = '0, req1_b = '0;
  logic         req1_ready;
  logic [W-1:0] mul_a, mul_b, mul_c;
  logic         mul_s;
  logic         rsp0_valid, rsp1_valid;
  logic [W-1:0] rsp0_data, rsp1_data;
  logic [3:0]   inflight;

  mult_arb_sched #(.LAT(LAT), .W(W)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_s(req0_s), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_s(req1_s), .req1_ready(req1_ready),
    .mul_a(mul_a), .mul_b(mul_b), .mul_s(mul_s), .mul_c(mul_c),
    .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data),
    .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data),
    .inflight(inflight)
  );

  always #5 clk = ~clk;

  // Multiplier model: registered operands reach the select mux LAT-1 edges later.
  logic [2*W-1:0] pipe [0:LAT-2];
  always @(posedge clk) begin
    pipe[0] <= {32'b0, mul_a} * {32'b0, mul_b};
    for (int i = 1; i < LAT - 1; i++) pipe[i] <= pipe[i-1];
  end
  assign mul_c = mul_s ? pipe[LAT-2][W-1:0] : pipe[LAT-2][2*W-1:W];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic         id;
    logic [W-1:0] data;
    int           cyc;
  } rsp_t;
  rsp_t got_q[$];
  rsp_t exp_q[$];

  always @(negedge clk) begin
    if (rsp0_valid) got_q.push_back('{id: 1'b0, data: rsp0_data, cyc: cyc});
    if (rsp1_valid) got_q.push_back('{id: 1'b1, data: rsp1_data, cyc: cyc});
  end

  typedef struct {
    logic         id;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         s;
    logic [W-1:0] exp;
  } vec_t;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] last_data [2];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic set_req(input logic id, input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    if (id) begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_s = s;
    end else begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_s = s;
    end
  endtask

  task automatic push_exp(input logic id, input logic [W-1:0] d, input int c);
    exp_q.push_back('{id: id, data: d, cyc: c});
  endtask

  task automatic do_reset(input int n);
    set_idle();
    reset = 1'b0;
    repeat (n) tick();
    reset = 1'b1;
    last_data[0] = '0;
    last_data[1] = '0;
  endtask

  task automatic check_log(input string name);
    check({name, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      check({name, "_id"},   got_q[i].id,   exp_q[i].id);
      check({name, "_data"}, got_q[i].data, exp_q[i].data);
      check({name, "_cyc"},  got_q[i].cyc,  exp_q[i].cyc);
    end
  endtask

  // One isolated operation: grant, operand register, select alignment, latency, pulse, hold.
  task automatic run_op(input vec_t v);
    int lat;
    lat = -1;
    got_q.delete();
    set_req(v.id, v.a, v.b, v.s);
    #1;
    check("op_ready", {req1_ready, req0_ready}, v.id ? 2'b10 : 2'b01);
    tick();
    set_idle();
    check("op_inflight_acc", inflight, 1);
    check("op_mul_a", mul_a, v.a);
    check("op_mul_b", mul_b, v.b);
    for (int t = 1; t <= 10; t++) begin
      tick();
      if (t == LAT - 1) check("op_sel_align", mul_s, v.s);
      if (v.id ? rsp1_valid : rsp0_valid) begin
        lat = t;
        check("op_data", v.id ? rsp1_data : rsp0_data, v.exp);
        check("op_inflight_rsp", inflight, 0);
        break;
      end
    end
    check("op_latency", lat, LAT);
    tick();
    check("op_pulse", v.id ? rsp1_valid : rsp0_valid, 1'b0);
    check("op_sel_idle", mul_s, 1'b1);
    check("op_other_hold", v.id ? rsp0_data : rsp1_data, last_data[!v.id]);
    check("op_single_rsp", got_q.size(), 1);
    last_data[v.id] = v.exp;
  endtask

  vec_t vecs [8];
  vec_t post_rst;
  int   k0;

  initial begin
    vecs[0] = '{id: 1'b0, a: 32'd3,         b: 32'd5,         s: 1'b1, exp: 32'd15};
    vecs[1] = '{id: 1'b1, a: 32'hFFFFFFFF,  b: 32'd2,         s: 1'b0, exp: 32'h00000001};
    vecs[2] = '{id: 1'b1, a: 32'hFFFFFFFF,  b: 32'd2,         s: 1'b1, exp: 32'hFFFFFFFE};
    vecs[3] = '{id: 1'b0, a: 32'hFFFFFFFF,  b: 32'hFFFFFFFF,  s: 1'b0, exp: 32'hFFFFFFFE};
    vecs[4] = '{id: 1'b0, a: 32'hFFFFFFFF,  b: 32'hFFFFFFFF,  s: 1'b1, exp: 32'h00000001};
    vecs[5] = '{id: 1'b1, a: 32'h00010000,  b: 32'h00010000,  s: 1'b0, exp: 32'h00000001};
    vecs[6] = '{id: 1'b1, a: 32'h12345678,  b: 32'h00000010,  s: 1'b1, exp: 32'h23456780};
    vecs[7] = '{id: 1'b0, a: 32'h00000000,  b: 32'hDEADBEEF,  s: 1'b1, exp: 32'h00000000};
    post_rst = '{id: 1'b0, a: 32'd7, b: 32'd9, s: 1'b1, exp: 32'd63};

    // Reset state, with a request pending to show ready stays low.
    reset = 1'b0;
    repeat (3) tick();
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    check("rst_ready", {req1_ready, req0_ready}, 2'b00);
    check("rst_mul_a", mul_a, 0);
    check("rst_mul_b", mul_b, 0);
    check("rst_rsp", {rsp1_valid, rsp0_valid}, 2'b00);
    check("rst_rsp_data", {rsp1_data, rsp0_data}, 64'h0);
    check("rst_inflight", inflight, 0);
    check("rst_mul_s", mul_s, 1'b1);
    set_idle();
    reset = 1'b1;
    last_data[0] = '0;
    last_data[1] = '0;
    tick();

    for (int i = 0; i < 8; i++) run_op(vecs[i]);

    // Continuous contention from a fresh pointer: alternate grants starting at 0.
    do_reset(1);
    got_q.delete();
    exp_q.delete();
    for (int i = 0; i < 6; i++) begin
      set_req(1'b0, 32'(10 + i), 32'd3, 1'b1);
      set_req(1'b1, 32'(20 + i), 32'd3, 1'b1);
      #1;
      check("rr_ready", {req1_ready, req0_ready}, (i % 2 == 1) ? 2'b10 : 2'b01);
      tick();
      push_exp(1'(i % 2), 32'((((i % 2 == 1) ? 20 : 10) + i) * 3), cyc + LAT);
      check("rr_inflight", inflight, (i < 4) ? i + 1 : 4);
    end
    set_idle();
    repeat (LAT + 3) tick();
    check("rr_drained", inflight, 0);
    check_log("rr");

    // Lone requester 1 twice, then contention goes to 0; idle cycles keep the pointer.
    got_q.delete();
    exp_q.delete();
    for (int i = 0; i < 2; i++) begin
      set_req(1'b1, 32'(5 + i), 32'd7, 1'b1);
      #1;
      check("solo1_ready", {req1_ready, req0_ready}, 2'b10);
      tick();
      set_idle();
      push_exp(1'b1, 32'((5 + i) * 7), cyc + LAT);
    end
    set_req(1'b0, 32'd2, 32'd9, 1'b1);
    set_req(1'b1, 32'd4, 32'd4, 1'b1);
    #1;
    check("first_contention", {req1_ready, req0_ready}, 2'b01);
    tick();
    push_exp(1'b0, 32'd18, cyc + LAT);
    set_idle();
    #1;
    check("idle_ready", {req1_ready, req0_ready}, 2'b00);
    repeat (2) tick();
    set_req(1'b0, 32'd2, 32'd9, 1'b1);
    set_req(1'b1, 32'd4, 32'd4, 1'b1);
    #1;
    check("ptr_after_idle", {req1_ready, req0_ready}, 2'b10);
    tick();
    push_exp(1'b1, 32'd16, cyc + LAT);
    set_idle();
    repeat (LAT + 3) tick();
    check_log("ptr");

    // Back-to-back half-selects on product 0x1_00000002.
    got_q.delete();
    exp_q.delete();
    k0 = 0;
    for (int i = 0; i < 3; i++) begin
      set_req(1'b0, 32'h80000001, 32'd2, 1'(i != 1));
      #1;
      check("mix_ready", req0_ready, 1'b1);
      tick();
      if (i == 0) k0 = cyc;
      push_exp(1'b0, (i != 1) ? 32'h2 : 32'h1, cyc + LAT);
    end
    set_idle();
    check("mix_inflight", inflight, 3);
    tick();
    check("mix_sel0", mul_s, 1'b1);
    check("mix_sel0_cyc", cyc, k0 + LAT - 1);
    tick();
    check("mix_sel1", mul_s, 1'b0);
    tick();
    check("mix_sel2", mul_s, 1'b1);
    repeat (LAT + 2) tick();
    check_log("mix");

    // Reset two edges after two issues: both operations vanish.
    got_q.delete();
    exp_q.delete();
    set_req(1'b0, 32'd3, 32'd3, 1'b1);
    tick();
    set_req(1'b0, 32'd4, 32'd4, 1'b1);
    tick();
    check("mid_inflight_pre", inflight, 2);
    reset = 1'b0;
    #1;
    check("mid_ready_in_rst", req0_ready, 1'b0);
    tick();
    set_idle();
    reset = 1'b1;
    last_data[0] = '0;
    last_data[1] = '0;
    check("mid_inflight", inflight, 0);
    check("mid_mul_a", mul_a, 0);
    repeat (LAT + 4) tick();
    check("mid_inflight_after", inflight, 0);
    check_log("mid");
    run_op(post_rst);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/mult_arb_sched.md
Name: mult_arb_sched

Overview:
- Shares one pipelined 32x32 partial-product multiplier between two requesters (key-schedule and state-mix paths).
- Arbitrates requests round-robin, registers the multiplier operands and carries a per-operation tag (owner, half-select) alongside the multiplier pipeline.
- Drives the multiplier's combinational half-select at the cycle the product emerges, then returns the selected 32-bit half to the owning requester.

Parameters:
- LAT, 4, clock latency of the multiplier from operand inputs to its 64-bit sum; legal range 1..8.
- W, 32, operand and result width.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-low reset.
- req0_valid  input  1  requester 0 has an operation.
- req0_a  input  W  multiplicand.
- req0_b  input  W  multiplier.
- req0_s  input  1  1 = return low half, 0 = return high half.
- req0_ready  output  1  grant; a transfer occurs when req0_valid & req0_ready at a clock edge.
- req1_valid, req1_a, req1_b, req1_s, req1_ready  same as requester 0.
- mul_a  output  W  registered operand A to the multiplier.
- mul_b  output  W  registered operand B to the multiplier.
- mul_s  output  1  half-select to the multiplier, aligned with the product.
- mul_c  input  W  selected half returned by the multiplier.
- rsp0_valid  output  1  one-cycle pulse: rsp0_data is valid.
- rsp0_data  output  W  result for requester 0.
- rsp1_valid, rsp1_data  same as rsp0, for requester 1.
- inflight  output  4  number of accepted operations not yet returned.

Behaviour:
- Reset (reset==0 at an edge):
  - mul_a=0, mul_b=0.
  - All tag-pipeline valids cleared; in-flight operations are silently discarded and produce no response.
  - rsp*_valid=0, rsp*_data=0, inflight=0.
  - Priority pointer set so requester 0 wins the first contention.
  - While reset is held, req*_ready=0.
- Arbitration (combinational ready, one issue per cycle):
  - Only one valid: that requester gets ready=1.
  - Both valid: grant goes to the requester not granted most recently. The pointer updates only on an actual transfer.
  - Neither valid: no ready is asserted, and mul_a/mul_b hold their values.
  - No backpressure on the response side; the scheduler accepts every cycle.
- Issue, transfer at edge k:
  - mul_a/mul_b load the granted operands.
  - Tag stage 1 loads {valid=1, id, s}.
  - Tags shift one stage per edge through stages 1..LAT, with no stall.
- Select and return:
  - mul_s = s field of tag stage LAT when that stage is valid, else 1.
  - At edge k+LAT, with stage LAT valid: mul_c is captured into rsp<id>_data and rsp<id>_valid=1 for exactly one cycle. The other requester's rsp_valid=0 and its rsp_data holds.
  - End-to-end: accept at edge k gives response visible after edge k+LAT, i.e. LAT cycles.
- Ordering:
  - Responses return in acceptance order.
  - Back-to-back issues on consecutive cycles return on consecutive cycles.
- inflight:
  - +1 on transfer, -1 on response capture.
  - Simultaneous transfer and response leaves it unchanged.
  - Maximum value is LAT; it never wraps.
- Reset mid-operation: cleared tags guarantee no stale response after reset releases, even though the multiplier pipeline still drains old products.

Test Plan:
- LAT=4, reset released, req0 only with a=3, b=5, s=1 accepted at edge 0 -> mul_s=1 during cycle 4, rsp0_valid for one cycle after edge 4 with data 15; rsp1_valid never asserts; inflight goes 1 then 0.
- req1 with a=0xFFFFFFFF, b=2, s=0 -> rsp1_data=0x00000001 (high half); same operands with s=1 -> 0xFFFFFFFE.
- Both requesters valid continuously for 6 cycles -> grants alternate 0,1,0,1,0,1 starting with 0; responses alternate on 6 consecutive cycles in the same order; inflight peaks at 4.
- Only req1 valid for 2 cycles, then both valid -> first contention is granted to req0; pointer does not move on idle cycles.
- Two operations issued, reset asserted for one cycle 2 edges later -> no rsp_valid ever asserts for them; inflight=0; next request after release returns correctly at LAT.
- Mixed s values back-to-back (s=1,0,1 on products 0x1_00000002) -> mul_s follows 1,0,1 aligned to emerging products; returned data 0x00000002, 0x00000001, 0x00000002.
